rob: RTL and testbench

- Reorder buffer: the producer end of the commit, tag-search and clear interface that the register file consumes.
- Allocates in-order entries at issue and captures results from writeback.
- Retires entries in order, driving commit to the register file and store release to the load/store unit.
- Detects branch mispredicts at commit and broadcasts a pipeline-wide clear with a redirect PC.

---
 rtl/rob_pkg.sv | 14 +
 rtl/rob.sv | 211 +++++++++++++++++++++
 tb/tb_rob.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// rob_pkg -- shared definitions for the reorder buffer.
//   ROB_WIDTH        : log2 of the entry count; also the width of every rob_id
//   ROB_DEPTH        : number of entries (2**ROB_WIDTH)
//   ROB_TYPE_*       : entry type encodings carried on issue_type
package rob_pkg;

  localparam int ROB_WIDTH = 3;
  localparam int ROB_DEPTH = 1 << ROB_WIDTH;

  localparam logic [1:0] ROB_TYPE_REG    = 2'd0;
  localparam logic [1:0] ROB_TYPE_BRANCH = 2'd1;
  localparam logic [1:0] ROB_TYPE_STORE  = 2'd2;

endpackage

// File: rtl/rob.sv
// rob -- in-order reorder buffer.
//
// Allocates entries at issue, captures results from writeback, and retires
// at most one ready head entry per cycle. A retiring entry produces a
// one-cycle commit pulse on the following cycle: REG/BRANCH entries write
// their rd, STORE entries raise commit_store. A retiring BRANCH whose
// resolved direction disagrees with its prediction flushes the whole buffer
// and pulses clear with the redirect PC, alongside its own commit pulse.
//
// Ports
//   clk_in, rst_in (async, active high), rdy_in (low = pause)
//   issue_*      : allocation request; issue_rob_id = tail, full = no free slot
//   wb_*         : result broadcast (tag, value, resolved branch direction)
//   search_*_1/2 : combinational tag lookup with writeback bypass
//   commit_*     : registered retire pulse toward the register file / LSU
//   clear, clear_pc : registered flush pulse and redirect target
//
// Build option
//   ROB_COMMIT_TRACE_EN : adds output commit_count, a 32-bit count of commit
//                         pulses for IPC tracing. Absent by default.
module rob
  import rob_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,

  input  logic                 issue_valid,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_pred_taken,
  input  logic [31:0]          issue_alt_pc,
  output logic [ROB_WIDTH-1:0] issue_rob_id,
  output logic                 full,

  input  logic                 wb_valid,
  input  logic [ROB_WIDTH-1:0] wb_rob_id,
  input  logic [31:0]          wb_val,
  input  logic                 wb_taken,

  input  logic [ROB_WIDTH-1:0] search_rob_id_1,
  input  logic [ROB_WIDTH-1:0] search_rob_id_2,
  output logic                 search_ready_1,
  output logic                 search_ready_2,
  output logic [31:0]          search_val_1,
  output logic [31:0]          search_val_2,

  output logic                 commit_ready,
  output logic [4:0]           commit_reg_id,
  output logic [31:0]          commit_val,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 commit_store,
`ifdef ROB_COMMIT_TRACE_EN
  output logic [31:0]          commit_count,
`endif
  output logic                 clear,
  output logic [31:0]          clear_pc
);

  localparam logic [ROB_WIDTH:0]   CNT_FULL = (ROB_WIDTH+1)'(ROB_DEPTH);
  localparam logic [ROB_WIDTH:0]   CNT_ONE  = (ROB_WIDTH+1)'(1);
  localparam logic [ROB_WIDTH-1:0] ID_ONE   = ROB_WIDTH'(1);

  // Pointers and occupancy
  logic [ROB_WIDTH-1:0] head, tail;
  logic [ROB_WIDTH:0]   count;

  // Per-entry control bits (reset) and payload (not reset)
  logic [ROB_DEPTH-1:0] entry_busy;
  logic [ROB_DEPTH-1:0] entry_ready;
  logic [1:0]           entry_type  [ROB_DEPTH];
  logic [4:0]           entry_rd    [ROB_DEPTH];
  logic                 entry_pred  [ROB_DEPTH];
  logic                 entry_taken [ROB_DEPTH];
  logic [31:0]          entry_alt_pc[ROB_DEPTH];
  logic [31:0]          entry_val   [ROB_DEPTH];

  logic retire, mispredict, head_is_store;
  logic issue_fire, wb_fire;

  assign full         = (count == CNT_FULL);
  assign issue_rob_id = tail;

  // Retire looks only at registered ready: a result written at this edge
  // retires no earlier than the next one.
  assign retire        = (count != '0) && entry_ready[head];
  assign head_is_store = (entry_type[head] == ROB_TYPE_STORE);
  assign mispredict    = retire && (entry_type[head] == ROB_TYPE_BRANCH) &&
                         (entry_taken[head] != entry_pred[head]);

  // A flush (this edge) or a pending clear pulse (previous flush) drops
  // both the incoming issue and the incoming writeback.
  assign issue_fire = issue_valid && !full && !clear && !mispredict;
  assign wb_fire    = wb_valid && entry_busy[wb_rob_id] && !clear && !mispredict;

  // Control state and registered outputs.
  // NOTE: sequential state uses non-blocking assignment so every register in
  // this block samples the pre-edge values; later assignments to the same
  // bit in the block (retire after writeback) deliberately win.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      entry_busy    <= '0;
      entry_ready   <= '0;
      commit_ready  <= 1'b0;
      commit_reg_id <= '0;
      commit_val    <= '0;
      commit_rob_id <= '0;
      commit_store  <= 1'b0;
      clear         <= 1'b0;
      clear_pc      <= '0;
    end else if (rdy_in) begin
      commit_ready  <= retire;
      commit_store  <= retire && head_is_store;
      commit_reg_id <= (retire && !head_is_store) ? entry_rd[head] : '0;
      commit_val    <= retire ? entry_val[head] : '0;
      commit_rob_id <= retire ? head : '0;
      clear         <= mispredict;
      clear_pc      <= mispredict ? entry_alt_pc[head] : '0;

      if (mispredict) begin
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        entry_busy  <= '0;
        entry_ready <= '0;
      end else begin
        if (issue_fire) begin
          entry_busy[tail]  <= 1'b1;
          entry_ready[tail] <= 1'b0;
          tail              <= tail + ID_ONE;
        end
        if (wb_fire) begin
          entry_ready[wb_rob_id] <= 1'b1;
        end
        if (retire) begin
          entry_busy[head]  <= 1'b0;
          entry_ready[head] <= 1'b0;
          head              <= head + ID_ONE;
        end
        case ({issue_fire, retire})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end else begin
      // Paused: state holds, but pulses drop so nothing is delivered twice.
      commit_ready  <= 1'b0;
      commit_store  <= 1'b0;
      commit_reg_id <= '0;
      commit_val    <= '0;
      commit_rob_id <= '0;
      clear         <= 1'b0;
      clear_pc      <= '0;
    end
  end

  // Entry payload.
  // NOTE: payload storage has no reset; busy/ready gate every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (issue_fire) begin
        entry_type[tail]   <= issue_type;
        entry_rd[tail]     <= issue_rd;
        entry_pred[tail]   <= issue_pred_taken;
        entry_alt_pc[tail] <= issue_alt_pc;
      end
      if (wb_fire) begin
        entry_val[wb_rob_id]   <= wb_val;
        entry_taken[wb_rob_id] <= wb_taken;
      end
    end
  end

`ifdef ROB_COMMIT_TRACE_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      commit_count <= '0;
    end else if (rdy_in && retire) begin
      commit_count <= commit_count + 32'd1;
    end
  end
`endif

  // Tag search with same-cycle writeback bypass.
  logic [ROB_WIDTH-1:0] search_tag [2];
  logic                 search_rdy [2];
  logic [31:0]          search_v   [2];

  assign search_tag[0] = search_rob_id_1;
  assign search_tag[1] = search_rob_id_2;

  for (genvar k = 0; k < 2; k++) begin : g_search
    logic hit;
    assign hit           = wb_valid && (wb_rob_id == search_tag[k]);
    assign search_rdy[k] = entry_busy[search_tag[k]] &&
                           (entry_ready[search_tag[k]] || hit);
    assign search_v[k]   = !search_rdy[k] ? 32'd0 :
                           hit            ? wb_val : entry_val[search_tag[k]];
  end

  assign search_ready_1 = search_rdy[0];
  assign search_ready_2 = search_rdy[1];
  assign search_val_1   = search_v[0];
  assign search_val_2   = search_v[1];

endmodule

// File: tb/tb_rob.sv
// tb_rob -- directed self-checking bench for the reorder buffer.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_rob;
  import rob_pkg::*;

  logic                 clk_in, rst_in, rdy_in;
  logic                 issue_valid;
  logic [1:0]           issue_type;
  logic [4:0]           issue_rd;
  logic                 issue_pred_taken;
  logic [31:0]          issue_alt_pc;
  logic [ROB_WIDTH-1:0] issue_rob_id;
  logic                 full;
  logic                 wb_valid;
  logic [ROB_WIDTH-1:0] wb_rob_id;
  logic [31:0]          wb_val;
  logic                 wb_taken;
  logic [ROB_WIDTH-1:0] search_rob_id_1, search_rob_id_2;
  logic                 search_ready_1, search_ready_2;
  logic [31:0]          search_val_1, search_val_2;
  logic                 commit_ready;
  logic [4:0]           commit_reg_id;
  logic [31:0]          commit_val;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic                 commit_store;
`ifdef ROB_COMMIT_TRACE_EN
  logic [31:0]          commit_count;
`endif
  logic                 clear;
  logic [31:0]          clear_pc;

  int n_tests = 0;
  int n_fail  = 0;

  rob dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .issue_valid      (issue_valid),
    .issue_type       (issue_type),
    .issue_rd         (issue_rd),
    .issue_pred_taken (issue_pred_taken),
    .issue_alt_pc     (issue_alt_pc),
    .issue_rob_id     (issue_rob_id),
    .full             (full),
    .wb_valid         (wb_valid),
    .wb_rob_id        (wb_rob_id),
    .wb_val           (wb_val),
    .wb_taken         (wb_taken),
    .search_rob_id_1  (search_rob_id_1),
    .search_rob_id_2  (search_rob_id_2),
    .search_ready_1   (search_ready_1),
    .search_ready_2   (search_ready_2),
    .search_val_1     (search_val_1),
    .search_val_2     (search_val_2),
    .commit_ready     (commit_ready),
    .commit_reg_id    (commit_reg_id),
    .commit_val       (commit_val),
    .commit_rob_id    (commit_rob_id),
    .commit_store     (commit_store),
`ifdef ROB_COMMIT_TRACE_EN
    .commit_count     (commit_count),
`endif
    .clear            (clear),
    .clear_pc         (clear_pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] rd,
                          input logic pred, input logic [31:0] alt);
    issue_valid      = 1'b1;
    issue_type       = t;
    issue_rd         = rd;
    issue_pred_taken = pred;
    issue_alt_pc     = alt;
    tick();
    issue_valid      = 1'b0;
  endtask

  task automatic do_wb(input logic [ROB_WIDTH-1:0] id, input logic [31:0] v,
                       input logic taken);
    wb_valid  = 1'b1;
    wb_rob_id = id;
    wb_val    = v;
    wb_taken  = taken;
    tick();
    wb_valid  = 1'b0;
  endtask

  initial begin
    logic [ROB_WIDTH-1:0] id;

    rst_in = 1'b1; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_type = ROB_TYPE_REG; issue_rd = '0;
    issue_pred_taken = 1'b0; issue_alt_pc = '0;
    wb_valid = 1'b0; wb_rob_id = '0; wb_val = '0; wb_taken = 1'b0;
    search_rob_id_1 = '0; search_rob_id_2 = '0;

    // Reset state
    repeat (2) tick();
    check("rst commit_ready", commit_ready, 0);
    check("rst clear", clear, 0);
    check("rst clear_pc", clear_pc, 0);
    check("rst full", full, 0);
    check("rst issue_rob_id", issue_rob_id, 0);
    rst_in = 1'b0;
    tick();

    // Single REG entry: issue, writeback, retire one edge later
    do_issue(ROB_TYPE_REG, 5'd5, 1'b0, 32'h0);
    do_wb(3'd0, 32'h1234, 1'b0);
    check("t1 no early commit", commit_ready, 0);
    tick();
    check("t1 commit_ready", commit_ready, 1);
    check("t1 commit_reg_id", commit_reg_id, 5);
    check("t1 commit_val", commit_val, 32'h1234);
    check("t1 commit_rob_id", commit_rob_id, 0);
    check("t1 commit_store", commit_store, 0);
    tick();
    check("t1 pulse ends", commit_ready, 0);
    check("t1 reg idle zero", commit_reg_id, 0);
    check("t1 val idle zero", commit_val, 0);

    // Fill all 8 entries (ids 1..7,0), rd = id+8
    for (int i = 0; i < 8; i++) begin
      id = ROB_WIDTH'(1 + i);
      do_issue(ROB_TYPE_REG, 5'(id) + 5'd8, 1'b0, 32'h0);
    end
    check("t2 full", full, 1);
    check("t2 tail wrapped", issue_rob_id, 1);
    do_issue(ROB_TYPE_REG, 5'd31, 1'b0, 32'h0);
    check("t2 9th dropped full", full, 1);
    check("t2 9th dropped tail", issue_rob_id, 1);
    do_wb(3'd1, 32'h101, 1'b0);
    check("t2 still full", full, 1);
    // Retire edge: slot freed by retire is not usable by this edge's issue
    issue_valid = 1'b1; issue_rd = 5'd30;
    tick();
    issue_valid = 1'b0;
    check("t2 full drops", full, 0);
    check("t2 retire id", commit_rob_id, 1);
    check("t2 retire rd", commit_reg_id, 9);
    check("t2 no same-edge issue", issue_rob_id, 1);
    // Drain in order
    for (int j = 2; j <= 8; j++) begin
      id = ROB_WIDTH'(j);
      wb_valid = 1'b1; wb_rob_id = id; wb_val = 32'h100 + 32'(id); wb_taken = 1'b0;
      tick();
      if (j == 2) begin
        check("t2 drain gap", commit_ready, 0);
      end else begin
        check("t2 drain id", commit_rob_id, 32'((j - 1) % 8));
        check("t2 drain val", commit_val, 32'h100 + 32'((j - 1) % 8));
      end
    end
    wb_valid = 1'b0;
    tick();
    check("t2 last id", commit_rob_id, 0);
    check("t2 last rd", commit_reg_id, 8);
    check("t2 last val", commit_val, 32'h100);
    check("t2 empty tail", issue_rob_id, 1);

    // Out-of-order writeback, in-order commit (ids 1,2,3)
    do_issue(ROB_TYPE_REG, 5'd1, 1'b0, 32'h0);
    do_issue(ROB_TYPE_REG, 5'd2, 1'b0, 32'h0);
    do_issue(ROB_TYPE_REG, 5'd3, 1'b0, 32'h0);
    do_wb(3'd3, 32'h33, 1'b0);
    tick();
    check("t3 youngest waits", commit_ready, 0);
    do_wb(3'd1, 32'h11, 1'b0);
    check("t3 head just ready", commit_ready, 0);
    do_wb(3'd2, 32'h22, 1'b0);
    check("t3 first id", commit_rob_id, 1);
    check("t3 first val", commit_val, 32'h11);
    tick();
    check("t3 second id", commit_rob_id, 2);
    check("t3 second val", commit_val, 32'h22);
    tick();
    check("t3 third id", commit_rob_id, 3);
    check("t3 third val", commit_val, 32'h33);

    // Mispredicted branch (id 4) with two ready younger entries
    do_issue(ROB_TYPE_BRANCH, 5'd1, 1'b0, 32'h100);
    do_issue(ROB_TYPE_REG, 5'd7, 1'b0, 32'h0);
    do_issue(ROB_TYPE_REG, 5'd8, 1'b0, 32'h0);
    do_wb(3'd5, 32'h55, 1'b0);
    do_wb(3'd6, 32'h66, 1'b0);
    do_wb(3'd4, 32'h44, 1'b1);
    issue_valid = 1'b1; issue_type = ROB_TYPE_REG; issue_rd = 5'd9;
    tick();
    check("t4 clear", clear, 1);
    check("t4 clear_pc", clear_pc, 32'h100);
    check("t4 br commit", commit_ready, 1);
    check("t4 br id", commit_rob_id, 4);
    check("t4 br link rd", commit_reg_id, 1);
    check("t4 br val", commit_val, 32'h44);
    check("t4 tail reset", issue_rob_id, 0);
    check("t4 not full", full, 0);
    tick();
    check("t4 clear ends", clear, 0);
    check("t4 clear_pc ends", clear_pc, 0);
    check("t4 no younger commit", commit_ready, 0);
    check("t4 issue under clear dropped", issue_rob_id, 0);
    issue_valid = 1'b0;
    tick();
    check("t4 still no commit", commit_ready, 0);

    // Correctly predicted branch (id 0), then a STORE (id 1)
    do_issue(ROB_TYPE_BRANCH, 5'd0, 1'b1, 32'h200);
    do_wb(3'd0, 32'h80, 1'b1);
    tick();
    check("t4b commit", commit_ready, 1);
    check("t4b no clear", clear, 0);
    do_issue(ROB_TYPE_STORE, 5'd9, 1'b0, 32'h0);
    do_wb(3'd1, 32'hDEAD, 1'b0);
    tick();
    check("st commit_ready", commit_ready, 1);
    check("st commit_store", commit_store, 1);
    check("st reg zero", commit_reg_id, 0);
    check("st val", commit_val, 32'hDEAD);
    tick();
    check("st pulse ends", commit_store, 0);

    // Search with bypass (ids 2,3)
    do_issue(ROB_TYPE_REG, 5'd4, 1'b0, 32'h0);
    do_issue(ROB_TYPE_REG, 5'd5, 1'b0, 32'h0);
    wb_valid = 1'b1; wb_rob_id = 3'd3; wb_val = 32'hBEEF; wb_taken = 1'b0;
    search_rob_id_1 = 3'd3; search_rob_id_2 = 3'd2;
    #1;
    check("s bypass ready", search_ready_1, 1);
    check("s bypass val", search_val_1, 32'hBEEF);
    check("s pending ready", search_ready_2, 0);
    check("s pending val", search_val_2, 0);
    search_rob_id_2 = 3'd5;
    #1;
    check("s idle tag ready", search_ready_2, 0);
    check("s idle tag val", search_val_2, 0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("s stored ready", search_ready_1, 1);
    check("s stored val", search_val_1, 32'hBEEF);
    do_wb(3'd7, 32'h77, 1'b0);
    search_rob_id_2 = 3'd7;
    #1;
    check("s wb to idle ignored", search_ready_2, 0);

    // Async reset with 4 entries in flight and a commit pulse high
    do_issue(ROB_TYPE_REG, 5'd6, 1'b0, 32'h0);
    do_issue(ROB_TYPE_REG, 5'd7, 1'b0, 32'h0);
    do_issue(ROB_TYPE_REG, 5'd8, 1'b0, 32'h0);
    do_wb(3'd2, 32'h22, 1'b0);
    tick();
    check("r pre commit", commit_ready, 1);
    #2 rst_in = 1'b1;
    #1;
    check("r async commit_ready", commit_ready, 0);
    check("r async commit_rob_id", commit_rob_id, 0);
    check("r async commit_val", commit_val, 0);
    check("r async full", full, 0);
    check("r async tail", issue_rob_id, 0);
    search_rob_id_1 = 3'd3;
    #1;
    check("r busy cleared", search_ready_1, 0);
    #2 rst_in = 1'b0;
    tick();
    do_issue(ROB_TYPE_REG, 5'd3, 1'b0, 32'h0);
    check("r first issue id0", issue_rob_id, 1);

    // Pause: writeback and issue have no effect while rdy_in is low
    rdy_in = 1'b0;
    wb_valid = 1'b1; wb_rob_id = 3'd0; wb_val = 32'h55;
    issue_valid = 1'b1;
    tick();
    wb_valid = 1'b0; issue_valid = 1'b0;
    search_rob_id_1 = 3'd0;
    #1;
    check("p wb held off", search_ready_1, 0);
    check("p issue held off", issue_rob_id, 1);
    rdy_in = 1'b1;
    do_wb(3'd0, 32'h55, 1'b0);
    tick();
    check("p resume commit", commit_ready, 1);
    check("p resume val", commit_val, 32'h55);
    check("p resume rd", commit_reg_id, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
